branch_redirect_ctrl: RTL and testbench

//  Sequences branch resolution for the decode-stage BranchUnit. Holds the branch in ID

---
 rtl/branch_redirect_ctrl_pkg.sv | 21 ++
 rtl/branch_redirect_ctrl_br_sat_counter.sv | 23 ++
 rtl/branch_redirect_ctrl.sv | 130 +++++++++++++
 tb/tb_branch_redirect_ctrl.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_redirect_ctrl_pkg.sv
// Shared state encoding and operand-readiness helper for the branch redirect controller.
// State width is fixed at two bits; IDLE encodes as zero so a cleared register is idle.
package branch_redirect_ctrl_pkg;

  localparam int BRC_ST_WD = 2;

  typedef enum logic [BRC_ST_WD-1:0] {
    BRC_ST_IDLE  = 2'd0,
    BRC_ST_WAIT  = 2'd1,
    BRC_ST_REDIR = 2'd2,
    BRC_ST_DRAIN = 2'd3
  } brc_state_e;

  // src2 only matters for compare branches (beq/bne).
  function automatic logic brc_opnd_ok(input logic src1_rdy,
                                       input logic src2_rdy,
                                       input logic uses_src2);
    return src1_rdy & (src2_rdy | ~uses_src2);
  endfunction

endpackage

// File: rtl/branch_redirect_ctrl_br_sat_counter.sv
// Saturating up-counter for branch statistics; sticks at all-ones, cleared only by reset.
module br_sat_counter #(
  parameter int WD = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc,
  output logic [WD-1:0] cnt
);

  logic [WD-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (inc && (r_cnt != '1)) begin
      r_cnt <= r_cnt + WD'(1);
    end
  end

  assign cnt = r_cnt;

endmodule

// File: rtl/branch_redirect_ctrl.sv
// Branch resolution sequencer between ID (BranchUnit) and IF: operand wait, flush, PC redirect, stale-response drain.
// Optional statistics counters are built only when BRC_STATS_EN is defined.
module branch_redirect_ctrl
  import branch_redirect_ctrl_pkg::*;
#(
  parameter int CNT_WD = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              br_valid,
  input  logic              br_uses_src2,
  input  logic              src_1_ready,
  input  logic              src_2_ready,
  input  logic              br_taken_cancel,
  input  logic [31:0]       next_PC,
  input  logic              redirect_ready,
  input  logic              fetch_outstanding,
  input  logic              fetch_resp_valid,
  output logic              id_stall,
  output logic              flush_if,
  output logic              redirect_valid,
  output logic [31:0]       redirect_pc,
  output logic              discard_resp,
  output logic [CNT_WD-1:0] stat_br_cnt,
  output logic [CNT_WD-1:0] stat_mis_cnt,
  output logic [BRC_ST_WD-1:0] dbg_state
);

  brc_state_e  r_state;
  brc_state_e  w_next_state;
  logic [31:0] r_redirect_pc;
  logic        w_opnd_ok;
  logic        w_resolve;
  logic        w_mispredict;
  logic        w_id_stall;
  logic        w_flush_if;
  logic        w_redirect_valid;
  logic        w_discard_resp;

  assign w_opnd_ok    = brc_opnd_ok(src_1_ready, src_2_ready, br_uses_src2);
  assign w_resolve    = ((r_state == BRC_ST_IDLE) || (r_state == BRC_ST_WAIT)) &&
                        br_valid && w_opnd_ok;
  assign w_mispredict = w_resolve && br_taken_cancel;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= BRC_ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Redirect handshake: redirect_valid stays high and redirect_pc stays constant
  // until a cycle where redirect_ready is also high; that cycle is the transfer.
  always_comb begin
    w_next_state     = r_state;
    w_id_stall       = 1'b0;
    w_flush_if       = 1'b0;
    w_redirect_valid = 1'b0;
    w_discard_resp   = 1'b0;
    case (r_state)
      BRC_ST_IDLE, BRC_ST_WAIT: begin
        if (!br_valid) begin
          w_next_state = BRC_ST_IDLE;
        end else if (!w_opnd_ok) begin
          w_id_stall   = 1'b1;
          w_next_state = BRC_ST_WAIT;
        end else if (br_taken_cancel) begin
          w_flush_if   = 1'b1;
          w_next_state = BRC_ST_REDIR;
        end else begin
          w_next_state = BRC_ST_IDLE;
        end
      end
      BRC_ST_REDIR: begin
        w_redirect_valid = 1'b1;
        w_id_stall       = 1'b1;
        if (redirect_ready) begin
          w_next_state = fetch_outstanding ? BRC_ST_DRAIN : BRC_ST_IDLE;
        end
      end
      BRC_ST_DRAIN: begin
        w_id_stall     = 1'b1;
        w_discard_resp = fetch_resp_valid;
        if (fetch_resp_valid) begin
          w_next_state = BRC_ST_IDLE;
        end
      end
      default: begin
        w_next_state = BRC_ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_redirect_pc <= 32'h0;
    end else if (w_mispredict) begin
      r_redirect_pc <= next_PC;
    end
  end

  // Decoded outputs are forced low while reset is asserted, not only after the next edge.
  assign id_stall       = w_id_stall & ~reset;
  assign flush_if       = w_flush_if & ~reset;
  assign redirect_valid = w_redirect_valid & ~reset;
  assign discard_resp   = w_discard_resp & ~reset;
  assign redirect_pc    = r_redirect_pc;
  assign dbg_state      = r_state;

`ifdef BRC_STATS_EN
  br_sat_counter #(.WD(CNT_WD)) u_br_cnt (
    .clk (clk),
    .rst (reset),
    .inc (w_resolve),
    .cnt (stat_br_cnt)
  );

  br_sat_counter #(.WD(CNT_WD)) u_mis_cnt (
    .clk (clk),
    .rst (reset),
    .inc (w_mispredict),
    .cnt (stat_mis_cnt)
  );
`else
  assign stat_br_cnt  = '0;
  assign stat_mis_cnt = '0;
`endif

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Directed bench for branch_redirect_ctrl: operand wait, mispredict redirect, drain, reset abort, stats.
module tb_branch_redirect_ctrl;
  import branch_redirect_ctrl_pkg::*;

`ifdef BRC_STATS_EN
  localparam int CNT_WD = 4;
`else
  localparam int CNT_WD = 32;
`endif

  logic              clk;
  logic              reset;
  logic              br_valid;
  logic              br_uses_src2;
  logic              src_1_ready;
  logic              src_2_ready;
  logic              br_taken_cancel;
  logic [31:0]       next_PC;
  logic              redirect_ready;
  logic              fetch_outstanding;
  logic              fetch_resp_valid;
  logic              id_stall;
  logic              flush_if;
  logic              redirect_valid;
  logic [31:0]       redirect_pc;
  logic              discard_resp;
  logic [CNT_WD-1:0] stat_br_cnt;
  logic [CNT_WD-1:0] stat_mis_cnt;
  logic [1:0]        dbg_state;

  int          total;
  int          bad;
  int          n_br;
  int          n_mis;
  logic [31:0] exp_q[$];

  branch_redirect_ctrl #(.CNT_WD(CNT_WD)) dut (
    .clk               (clk),
    .reset             (reset),
    .br_valid          (br_valid),
    .br_uses_src2      (br_uses_src2),
    .src_1_ready       (src_1_ready),
    .src_2_ready       (src_2_ready),
    .br_taken_cancel   (br_taken_cancel),
    .next_PC           (next_PC),
    .redirect_ready    (redirect_ready),
    .fetch_outstanding (fetch_outstanding),
    .fetch_resp_valid  (fetch_resp_valid),
    .id_stall          (id_stall),
    .flush_if          (flush_if),
    .redirect_valid    (redirect_valid),
    .redirect_pc       (redirect_pc),
    .discard_resp      (discard_resp),
    .stat_br_cnt       (stat_br_cnt),
    .stat_mis_cnt      (stat_mis_cnt),
    .dbg_state         (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_stat(input int n);
`ifdef BRC_STATS_EN
    return (n > 15) ? 32'd15 : 32'(n);
`else
    return 32'd0;
`endif
  endfunction

  task automatic check_stats(input string tag);
    check({tag, "_br_cnt"}, 32'(stat_br_cnt), exp_stat(n_br));
    check({tag, "_mis_cnt"}, 32'(stat_mis_cnt), exp_stat(n_mis));
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    br_valid          = 1'b0;
    br_uses_src2      = 1'b0;
    src_1_ready       = 1'b0;
    src_2_ready       = 1'b0;
    br_taken_cancel   = 1'b0;
    next_PC           = 32'h0;
    redirect_ready    = 1'b0;
    fetch_outstanding = 1'b0;
    fetch_resp_valid  = 1'b0;
  endtask

  // Present a ready jirl/b-style branch with cancel; one resolve.
  task automatic drive_mispredict(input logic [31:0] pc);
    br_valid        = 1'b1;
    br_uses_src2    = 1'b0;
    src_1_ready     = 1'b1;
    br_taken_cancel = 1'b1;
    next_PC         = pc;
    n_br++;
    n_mis++;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    n_br  = 0;
    n_mis = 0;
    idle_inputs();
    reset = 1'b1;

    // Reset state: outputs held low even with a stalled branch presented.
    br_valid = 1'b1;
    sample();
    check("rst_state", 32'(dbg_state), 32'(BRC_ST_IDLE));
    check("rst_id_stall", 32'(id_stall), 32'd0);
    check("rst_redirect_valid", 32'(redirect_valid), 32'd0);
    check("rst_redirect_pc", redirect_pc, 32'h0);
    check_stats("rst");
    tick();
    reset = 1'b0;
    idle_inputs();
    tick();

    // Correct prediction: zero penalty.
    br_valid    = 1'b1;
    src_1_ready = 1'b1;
    next_PC     = 32'h1C000100;
    n_br++;
    sample();
    check("ok_id_stall", 32'(id_stall), 32'd0);
    check("ok_flush", 32'(flush_if), 32'd0);
    check("ok_redirect_valid", 32'(redirect_valid), 32'd0);
    tick();
    idle_inputs();
    sample();
    check("ok_state", 32'(dbg_state), 32'(BRC_ST_IDLE));
    check("ok_redirect_valid2", 32'(redirect_valid), 32'd0);
    check_stats("ok");
    tick();

    // beq waits 3 cycles on src2; cancel is ignored until operands are ready.
    br_valid        = 1'b1;
    br_uses_src2    = 1'b1;
    src_1_ready     = 1'b1;
    src_2_ready     = 1'b0;
    br_taken_cancel = 1'b1;
    next_PC         = 32'h1C000040;
    for (int i = 0; i < 3; i++) begin
      sample();
      check($sformatf("wait%0d_id_stall", i), 32'(id_stall), 32'd1);
      check($sformatf("wait%0d_flush", i), 32'(flush_if), 32'd0);
      tick();
    end
    src_2_ready = 1'b1;
    n_br++;
    n_mis++;
    exp_q.push_back(32'h1C000040);
    sample();
    check("beq_flush", 32'(flush_if), 32'd1);
    check("beq_redirect_valid", 32'(redirect_valid), 32'd0);
    check("beq_id_stall", 32'(id_stall), 32'd0);
    tick();

    // IF back-pressures the redirect for 4 cycles; ID inputs change but are ignored.
    next_PC        = 32'hDEADBEEF;
    redirect_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sample();
      check($sformatf("hold%0d_redirect_valid", i), 32'(redirect_valid), 32'd1);
      check($sformatf("hold%0d_redirect_pc", i), redirect_pc, exp_q[0]);
      check($sformatf("hold%0d_id_stall", i), 32'(id_stall), 32'd1);
      check($sformatf("hold%0d_flush", i), 32'(flush_if), 32'd0);
      tick();
    end
    idle_inputs();
    redirect_ready = 1'b1;
    sample();
    check("acc_redirect_valid", 32'(redirect_valid), 32'd1);
    check("acc_redirect_pc", redirect_pc, exp_q.pop_front());
    tick();
    redirect_ready = 1'b0;
    sample();
    check("acc_state", 32'(dbg_state), 32'(BRC_ST_IDLE));
    check("acc_redirect_valid2", 32'(redirect_valid), 32'd0);
    check("acc_id_stall", 32'(id_stall), 32'd0);
    check_stats("acc");
    tick();

    // Accept with a wrong-path fetch in flight; its response arrives 2 cycles later.
    drive_mispredict(32'h1C001000);
    exp_q.push_back(32'h1C001000);
    sample();
    check("drn_flush", 32'(flush_if), 32'd1);
    tick();
    idle_inputs();
    redirect_ready    = 1'b1;
    fetch_outstanding = 1'b1;
    sample();
    check("drn_redirect_valid", 32'(redirect_valid), 32'd1);
    check("drn_redirect_pc", redirect_pc, exp_q.pop_front());
    tick();
    idle_inputs();
    sample();
    check("drn_wait_state", 32'(dbg_state), 32'(BRC_ST_DRAIN));
    check("drn_wait_id_stall", 32'(id_stall), 32'd1);
    check("drn_wait_discard", 32'(discard_resp), 32'd0);
    check("drn_wait_redirect_valid", 32'(redirect_valid), 32'd0);
    tick();
    fetch_resp_valid = 1'b1;
    sample();
    check("drn_resp_discard", 32'(discard_resp), 32'd1);
    check("drn_resp_id_stall", 32'(id_stall), 32'd1);
    tick();
    sample();
    check("drn_after_state", 32'(dbg_state), 32'(BRC_ST_IDLE));
    check("drn_after_discard", 32'(discard_resp), 32'd0);
    check("drn_after_id_stall", 32'(id_stall), 32'd0);
    tick();
    idle_inputs();

    // Reset while a redirect is pending and not yet accepted.
    drive_mispredict(32'h1C002000);
    tick();
    idle_inputs();
    sample();
    check("rr_redirect_valid", 32'(redirect_valid), 32'd1);
    check("rr_redirect_pc", redirect_pc, 32'h1C002000);
    tick();
    reset = 1'b1;
    n_br  = 0;
    n_mis = 0;
    sample();
    check("rr_async_redirect_valid", 32'(redirect_valid), 32'd0);
    tick();
    reset = 1'b0;
    sample();
    check("rr_state", 32'(dbg_state), 32'(BRC_ST_IDLE));
    check("rr_redirect_valid2", 32'(redirect_valid), 32'd0);
    check("rr_redirect_pc2", redirect_pc, 32'h0);
    check_stats("rr");
    tick();

    // 17 back-to-back mispredicts: counters saturate when built, read 0 otherwise.
    for (int k = 0; k < 17; k++) begin
      drive_mispredict(32'h1C003000 + 32'(k * 4));
      tick();
      idle_inputs();
      redirect_ready = 1'b1;
      sample();
      check($sformatf("sat%0d_redirect_pc", k), redirect_pc, 32'h1C003000 + 32'(k * 4));
      tick();
      redirect_ready = 1'b0;
      if (k == 13) begin
        sample();
        check_stats("sat14");
      end
    end
    sample();
    check_stats("sat17");
    check("sat_state", 32'(dbg_state), 32'(BRC_ST_IDLE));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
